// File: rtl/gic_pkg.sv
// Shared GIC definitions: link symbols used by gic_master/gic_slave and the
// arbiter state encoding.
package gic_pkg;

    localparam logic [3:0] GIC_SYM_IDLE  = 4'b1111;
    localparam logic [3:0] GIC_SYM_MINIT = 4'b1010;
    localparam logic [3:0] GIC_SYM_SINIT = 4'b0101;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1,
        ARB_ABORT  = 2'd2
    } arb_state_e;

    // Watchdog counter width; a disabled watchdog still gets a 1-bit register.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gic_rr_picker.sv
// Round-robin picker: first set request bit scanning upward from last+1 with wrap.
module gic_rr_picker
    import gic_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] last,
    output logic                           valid,
    output logic [$clog2(NUM_MASTERS)-1:0] idx
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);

    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand     = (32'(last) + k) % NUM_MASTERS;
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/gic_arbiter.sv
// Round-robin arbiter sharing one gic_master Wishbone port between NUM_MASTERS
// local masters; whole cycles are granted, with a watchdog abort.
module gic_arbiter
    import gic_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                      wbm_clk_i,
    input  logic                      wbm_rst_i,

    input  logic [32*NUM_MASTERS-1:0] wbs_adr_i,
    input  logic [32*NUM_MASTERS-1:0] wbs_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  wbs_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbs_we_i,
    input  logic [NUM_MASTERS-1:0]    wbs_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbs_stb_i,
    input  logic [3*NUM_MASTERS-1:0]  wbs_cti_i,
    input  logic [2*NUM_MASTERS-1:0]  wbs_bte_i,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_MASTERS-1:0]    wbs_ack_o,
    output logic [NUM_MASTERS-1:0]    wbs_err_o,
    output logic [NUM_MASTERS-1:0]    wbs_rty_o,

    output logic [31:0]               wbm_adr_o,
    output logic [31:0]               wbm_dat_o,
    output logic [3:0]                wbm_sel_o,
    output logic                      wbm_we_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic [2:0]                wbm_cti_o,
    output logic [1:0]                wbm_bte_o,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i,
    input  logic                      wbm_rty_i,
    input  logic [31:0]               wbm_dat_i,

    output logic [NUM_MASTERS-1:0]    arb_grant_o,
    output logic                      arb_timeout_o
);

    localparam int unsigned IW  = $clog2(NUM_MASTERS);
    localparam int unsigned WDW = wd_width(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    arb_state_e     state_r, state_nx;
    logic [IW-1:0]  grant_idx_r;
    logic [IW-1:0]  last_r;
    logic [WDW-1:0] wd_r, wd_nx;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic           done;
    logic           unused_ok;

    logic [31:0]    adr_a [NUM_MASTERS];
    logic [31:0]    dat_a [NUM_MASTERS];
    logic [3:0]     sel_a [NUM_MASTERS];

    // Burst hints are not supported; only classic cycles pass through.
    assign unused_ok = ^{wbs_cti_i, wbs_bte_i};

    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;
    assign wbs_dat_o = wbm_dat_i;
    assign done      = wbm_ack_i | wbm_err_i | wbm_rty_i;

    always_comb begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            adr_a[i] = wbs_adr_i[32*i +: 32];
            dat_a[i] = wbs_dat_i[32*i +: 32];
            sel_a[i] = wbs_sel_i[4*i +: 4];
        end
    end

    gic_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req  (wbs_cyc_i),
        .last (last_r),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i) begin
            state_r     <= ARB_IDLE;
            grant_idx_r <= '0;
            last_r      <= IW'(NUM_MASTERS - 1);
            wd_r        <= '0;
        end else begin
            state_r <= state_nx;
            wd_r    <= wd_nx;
            if (state_r == ARB_IDLE && pick_valid) begin
                grant_idx_r <= pick_idx;
                last_r      <= pick_idx;
            end
        end
    end

    always_comb begin
        state_nx      = state_r;
        wd_nx         = '0;
        wbm_adr_o     = adr_a[grant_idx_r];
        wbm_dat_o     = dat_a[grant_idx_r];
        wbm_sel_o     = sel_a[grant_idx_r];
        wbm_we_o      = wbs_we_i[grant_idx_r];
        wbm_cyc_o     = 1'b0;
        wbm_stb_o     = 1'b0;
        wbs_ack_o     = '0;
        wbs_err_o     = '0;
        wbs_rty_o     = '0;
        arb_grant_o   = '0;
        arb_timeout_o = 1'b0;

        case (state_r)
            ARB_IDLE: begin
                if (pick_valid) state_nx = ARB_ACTIVE;
            end
            ARB_ACTIVE: begin
                wbm_cyc_o                = wbs_cyc_i[grant_idx_r];
                wbm_stb_o                = wbs_stb_i[grant_idx_r];
                wbs_ack_o[grant_idx_r]   = wbm_ack_i;
                wbs_err_o[grant_idx_r]   = wbm_err_i;
                wbs_rty_o[grant_idx_r]   = wbm_rty_i;
                arb_grant_o[grant_idx_r] = 1'b1;
                // A cyc drop releases the link ahead of any watchdog expiry;
                // a completion in the expiry cycle also cancels the abort.
                if (!wbs_cyc_i[grant_idx_r]) begin
                    state_nx = ARB_IDLE;
                end else if (wbs_stb_i[grant_idx_r] && !done) begin
                    if (TIMEOUT != 0 && wd_r == WD_LAST) state_nx = ARB_ABORT;
                    else wd_nx = wd_r + WDW'(1);
                end
            end
            ARB_ABORT: begin
                wbs_err_o[grant_idx_r] = 1'b1;
                arb_timeout_o          = 1'b1;
                state_nx               = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gic_arbiter.sv
// Bench for gic_arbiter: constant vector table, hand-written corner sequences and
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_gic_arbiter;

    localparam int N  = 4;
    localparam int TO = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [31:0]   m_adr [N];
    logic [31:0]   m_dat [N];
    logic [3:0]    m_sel [N];
    logic [N-1:0]  m_we, m_cyc, m_stb;
    logic [3*N-1:0] cti;
    logic [2*N-1:0] bte;
    logic [32*N-1:0] adr_f, dat_f;
    logic [4*N-1:0]  sel_f;
    logic          s_ack, s_err, s_rty;
    logic [31:0]   s_dat;

    logic [31:0]   wbs_dat_o;
    logic [N-1:0]  wbs_ack_o, wbs_err_o, wbs_rty_o, arb_grant_o;
    logic [31:0]   wbm_adr_o, wbm_dat_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_we_o, wbm_cyc_o, wbm_stb_o, arb_timeout_o;
    logic [2:0]    wbm_cti_o;
    logic [1:0]    wbm_bte_o;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            adr_f[32*i +: 32] = m_adr[i];
            dat_f[32*i +: 32] = m_dat[i];
            sel_f[4*i +: 4]   = m_sel[i];
        end
    end

    gic_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .wbm_clk_i(clk), .wbm_rst_i(rst),
        .wbs_adr_i(adr_f), .wbs_dat_i(dat_f), .wbs_sel_i(sel_f),
        .wbs_we_i(m_we), .wbs_cyc_i(m_cyc), .wbs_stb_i(m_stb),
        .wbs_cti_i(cti), .wbs_bte_i(bte),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty), .wbm_dat_i(s_dat),
        .arb_grant_o(arb_grant_o), .arb_timeout_o(arb_timeout_o)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the link, whether this is the abort cycle,
    // the last winner, the index the data mux points at, and stalled stb cycles.
    int   own = -1;
    bit   in_abort = 1'b0;
    int   last = N - 1;
    int   msel = 0;
    int   stalls = 0;
    logic [N-1:0] exp_ack_last;

    task automatic model_check();
        logic [N-1:0] e_ack, e_err, e_rty, e_grant;
        logic e_cyc, e_stb, e_to;
        e_ack = '0; e_err = '0; e_rty = '0; e_grant = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_to = 1'b0;
        if (in_abort) begin
            e_err[own] = 1'b1;
            e_to = 1'b1;
        end else if (own >= 0) begin
            e_cyc = m_cyc[own];
            e_stb = m_stb[own];
            e_ack[own] = s_ack;
            e_err[own] = s_err;
            e_rty[own] = s_rty;
            e_grant[own] = 1'b1;
        end
        exp_ack_last = e_ack;
        chk("m_cyc", wbm_cyc_o, e_cyc);
        chk("m_stb", wbm_stb_o, e_stb);
        chk("m_ack", wbs_ack_o, e_ack);
        chk("m_err", wbs_err_o, e_err);
        chk("m_rty", wbs_rty_o, e_rty);
        chk("m_grant", arb_grant_o, e_grant);
        chk("m_timeout", arb_timeout_o, e_to);
        chk("m_adr", wbm_adr_o, m_adr[msel]);
        chk("m_wdat", wbm_dat_o, m_dat[msel]);
        chk("m_sel", wbm_sel_o, m_sel[msel]);
        chk("m_we", wbm_we_o, m_we[msel]);
        chk("m_rdat", wbs_dat_o, s_dat);
        chk("m_cti_bte", {wbm_cti_o, wbm_bte_o}, 5'b0);
    endtask

    task automatic model_update();
        if (rst) begin
            own = -1; in_abort = 1'b0; last = N - 1; msel = 0; stalls = 0;
        end else if (in_abort) begin
            in_abort = 1'b0; own = -1; stalls = 0;
        end else if (own >= 0) begin
            if (!m_cyc[own]) begin
                own = -1; stalls = 0;
            end else if (m_stb[own] && !(s_ack || s_err || s_rty)) begin
                stalls++;
                if (TO != 0 && stalls == TO) begin in_abort = 1'b1; stalls = 0; end
            end else begin
                stalls = 0;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (m_cyc[c]) begin own = c; last = c; msel = c; break; end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic cycle_tail();
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        settle();
        cycle_tail();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  cyc;
        logic [3:0]  stb;
        int          am;
        logic [31:0] adr;
        bit          we;
        bit          ack;
        logic [3:0]  e_grant;
        bit          e_cyc;
        logic [3:0]  e_ack;
        logic [31:0] e_adr;
    } vec_t;

    function automatic vec_t mk(bit r, logic [3:0] c, logic [3:0] s, int am, logic [31:0] a, bit w,
                                bit k, logic [3:0] eg, bit ec, logic [3:0] ek, logic [31:0] ea);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.am = am; v.adr = a; v.we = w; v.ack = k;
        v.e_grant = eg; v.e_cyc = ec; v.e_ack = ek; v.e_adr = ea;
        return v;
    endfunction

    vec_t vt [15];

    initial begin
        int order[$];
        logic [N-1:0] prev_g, drop;
        int to_at, pulses, errs;

        vt[0]  = mk(1, 4'b0000, 4'b0000, -1, 0,            0, 0, 4'b0000, 0, 4'b0000, 32'hA000_0000);
        vt[1]  = mk(0, 4'b0100, 4'b0100,  2, 32'h0000_1000, 0, 0, 4'b0000, 0, 4'b0000, 32'hA000_0000);
        vt[2]  = mk(0, 4'b0100, 4'b0100, -1, 0,            0, 1, 4'b0100, 1, 4'b0100, 32'h0000_1000);
        vt[3]  = mk(0, 4'b0000, 4'b0000, -1, 0,            0, 0, 4'b0100, 0, 4'b0000, 32'h0000_1000);
        vt[4]  = mk(0, 4'b0000, 4'b0000, -1, 0,            0, 0, 4'b0000, 0, 4'b0000, 32'h0000_1000);
        vt[5]  = mk(0, 4'b0010, 4'b0010,  1, 32'h0000_0010, 1, 0, 4'b0000, 0, 4'b0000, 32'h0000_1000);
        vt[6]  = mk(0, 4'b0011, 4'b0010, -1, 0,            0, 1, 4'b0010, 1, 4'b0010, 32'h0000_0010);
        vt[7]  = mk(0, 4'b0011, 4'b0000, -1, 0,            0, 0, 4'b0010, 1, 4'b0000, 32'h0000_0010);
        vt[8]  = mk(0, 4'b0011, 4'b0010,  1, 32'h0000_0014, 0, 0, 4'b0010, 1, 4'b0000, 32'h0000_0014);
        vt[9]  = mk(0, 4'b0011, 4'b0010, -1, 0,            0, 1, 4'b0010, 1, 4'b0010, 32'h0000_0014);
        vt[10] = mk(0, 4'b0001, 4'b0001, -1, 0,            0, 0, 4'b0010, 0, 4'b0000, 32'h0000_0014);
        vt[11] = mk(0, 4'b0001, 4'b0001, -1, 0,            0, 0, 4'b0000, 0, 4'b0000, 32'h0000_0014);
        vt[12] = mk(0, 4'b0001, 4'b0001, -1, 0,            0, 1, 4'b0001, 1, 4'b0001, 32'hA000_0000);
        vt[13] = mk(0, 4'b0000, 4'b0000, -1, 0,            0, 0, 4'b0001, 0, 4'b0000, 32'hA000_0000);
        vt[14] = mk(0, 4'b0000, 4'b0000, -1, 0,            0, 1, 4'b0000, 0, 4'b0000, 32'hA000_0000);

        for (int i = 0; i < N; i++) begin
            m_adr[i] = 32'hA000_0000 + i;
            m_dat[i] = 32'h5000_0000 + i;
            m_sel[i] = 4'hF;
        end
        m_we = '0; cti = '0; bte = '0; s_dat = 32'hDEAD_BEEF;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;

        // Directed vectors: lone read by master 2, then master 1 over two stb phases.
        for (int i = 0; i < 15; i++) begin
            rst = vt[i].rst; m_cyc = vt[i].cyc; m_stb = vt[i].stb; s_ack = vt[i].ack;
            if (vt[i].am >= 0) begin
                m_adr[vt[i].am] = vt[i].adr;
                m_we[vt[i].am]  = vt[i].we;
            end
            settle();
            chk($sformatf("tbl%0d_grant", i), arb_grant_o, vt[i].e_grant);
            chk($sformatf("tbl%0d_cyc", i), wbm_cyc_o, vt[i].e_cyc);
            chk($sformatf("tbl%0d_ack", i), wbs_ack_o, vt[i].e_ack);
            chk($sformatf("tbl%0d_adr", i), wbm_adr_o, vt[i].e_adr);
            chk($sformatf("tbl%0d_rdat", i), wbs_dat_o, 32'hDEAD_BEEF);
            cycle_tail();
        end
        rst = 1'b0;

        // All four request; each owner drops cyc after its ack then re-requests.
        do_reset();
        drop = '0; prev_g = '0;
        s_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_cyc = 4'hF & ~drop;
            m_stb = m_cyc;
            settle();
            if (arb_grant_o != '0 && arb_grant_o != prev_g)
                for (int b = 0; b < N; b++) if (arb_grant_o[b]) order.push_back(b);
            prev_g = arb_grant_o;
            cycle_tail();
            drop = exp_ack_last;
        end
        chk("rr_count", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("rr_order%0d", i), order[i], (i == 4) ? 0 : i);

        // Slave never answers: abort after 255 stalled stb cycles, late ack discarded.
        do_reset();
        to_at = -1;
        for (int i = 0; i <= 260; i++) begin
            m_cyc = (i <= 256) ? 4'b1000 : 4'b0000;
            m_stb = m_cyc;
            s_ack = (i == 259);
            settle();
            if (arb_timeout_o === 1'b1 && to_at < 0) to_at = i;
            if (i == 256) begin
                chk("to_err", wbs_err_o, 4'b1000);
                chk("to_cyc", wbm_cyc_o, 1'b0);
            end
            if (i == 259) chk("to_late_ack", wbs_ack_o, 4'b0000);
            cycle_tail();
        end
        chk("to_cycle", to_at, 256);

        // Ack lands on the cycle the watchdog would expire.
        do_reset();
        pulses = 0; errs = 0;
        for (int i = 0; i <= 258; i++) begin
            m_cyc = (i <= 255) ? 4'b1000 : 4'b0000;
            m_stb = m_cyc;
            s_ack = (i == 255);
            settle();
            if (arb_timeout_o === 1'b1) pulses++;
            if (wbs_err_o !== '0) errs++;
            if (i == 255) chk("edge_ack", wbs_ack_o, 4'b1000);
            cycle_tail();
        end
        chk("edge_pulses", pulses, 0);
        chk("edge_errs", errs, 0);

        // Reset during master 3's ACTIVE cycle; master 0 wins first afterwards.
        do_reset();
        for (int i = 0; i <= 4; i++) begin
            rst   = (i == 2);
            m_cyc = (i >= 2) ? 4'hF : 4'b1000;
            m_stb = m_cyc;
            settle();
            if (i == 2) chk("rst_before", arb_grant_o, 4'b1000);
            if (i == 3) begin
                chk("rst_grant", arb_grant_o, 4'b0000);
                chk("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o, arb_timeout_o}, 3'b000);
                chk("rst_compl", {wbs_ack_o, wbs_err_o, wbs_rty_o}, 12'h000);
                chk("rst_adr", wbm_adr_o, m_adr[0]);
            end
            if (i == 4) chk("rst_first", arb_grant_o, 4'b0001);
            cycle_tail();
        end
        rst = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(0, 3) == 0) m_cyc[m] = ~m_cyc[m];
                m_stb[m] = m_cyc[m] & $urandom_range(0, 1);
                m_adr[m] = $urandom;
                m_dat[m] = $urandom;
                m_sel[m] = 4'($urandom);
                m_we[m]  = 1'($urandom);
            end
            s_ack = ($urandom_range(0, 3) == 0);
            s_err = ($urandom_range(0, 7) == 0);
            s_rty = ($urandom_range(0, 7) == 0);
            s_dat = $urandom;
            cti   = 12'($urandom);
            bte   = 8'($urandom);
            settle();
            cycle_tail();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got no completion, expected finish before 1000000 ns");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
